// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register specifiers and forwarding-select encoding.
package cpu_types_pkg;

    localparam int REG_BITS = 5;

    typedef logic [REG_BITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Output bundle of the hazard unit: stall controls, forwarding selects and stall tracking.
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic                 pc_en;
    logic                 ifid_en;
    logic                 idex_flush;
    cpu_types_pkg::fwd_t  forwardA;
    cpu_types_pkg::fwd_t  forwardB;
    cpu_types_pkg::fwd_t  forwardSW;
    logic                 stalled;
    logic [CNT_W-1:0]     stall_count;

    modport hu (
        output pc_en, ifid_en, idex_flush, forwardA, forwardB, forwardSW,
               stalled, stall_count
    );

    modport tb (
        input pc_en, ifid_en, idex_flush, forwardA, forwardB, forwardSW,
              stalled, stall_count
    );
endinterface

// File: rtl/hazard_unit_forward_sel.sv
// Picks the youngest in-flight producer of a source register; MEM beats WB, $0 never forwards.
module forward_sel
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src_reg,
    input  logic             en,
    input  logic             exmem_wen,
    input  logic [REG_W-1:0] exmem_dst,
    input  logic             mem_wen,
    input  logic [REG_W-1:0] mem_dst,
    output fwd_t             sel
);

    logic exmem_hit_s;
    logic mem_hit_s;

    assign exmem_hit_s = exmem_wen && (exmem_dst != {REG_W{1'b0}}) && (exmem_dst == src_reg);
    assign mem_hit_s   = mem_wen && (mem_dst != {REG_W{1'b0}}) && (mem_dst == src_reg);

    // Priority select of the forwarding source
    always_comb begin
        sel = FWD_RF;
        if (!en) begin
            sel = FWD_RF;
        end else if (exmem_hit_s) begin
            sel = FWD_MEM;
        end else if (mem_hit_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall detection, EX forwarding selects and a registered stall flag/counter.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic [REG_W-1:0] idex_rs,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             MemRead,
    input  logic             idex_MemWrite,
    input  logic [REG_W-1:0] stall_rt,
    input  logic             exmem_RegWEN,
    input  logic [REG_W-1:0] exmem_RegDst,
    input  logic             mem_RegWEN,
    input  logic [REG_W-1:0] mem_RegDst,
    hazard_unit_if.hu        huif
);

    logic             hz_s;
    logic             stalled_d;
    logic             stalled_q;
    logic [CNT_W-1:0] stall_count_d;
    logic [CNT_W-1:0] stall_count_q;

    // stalled_q blocks a second stall on the same load once the bubble is in flight
    assign hz_s = MemRead && (stall_rt != {REG_W{1'b0}})
               && ((stall_rt == ifid_rs) || (stall_rt == ifid_rt)) && !stalled_q;

    // Pipeline enables and bubble insertion
    always_comb begin
        huif.pc_en      = 1'b1;
        huif.ifid_en    = 1'b1;
        huif.idex_flush = 1'b0;
        if (hz_s) begin
            huif.pc_en      = 1'b0;
            huif.ifid_en    = 1'b0;
            huif.idex_flush = 1'b1;
        end else begin
            huif.pc_en      = 1'b1;
            huif.ifid_en    = 1'b1;
            huif.idex_flush = 1'b0;
        end
    end

    forward_sel #(.REG_W(REG_W)) u_fwd_a (
        .src_reg   (idex_rs),
        .en        (1'b1),
        .exmem_wen (exmem_RegWEN),
        .exmem_dst (exmem_RegDst),
        .mem_wen   (mem_RegWEN),
        .mem_dst   (mem_RegDst),
        .sel       (huif.forwardA)
    );

    forward_sel #(.REG_W(REG_W)) u_fwd_b (
        .src_reg   (idex_rt),
        .en        (1'b1),
        .exmem_wen (exmem_RegWEN),
        .exmem_dst (exmem_RegDst),
        .mem_wen   (mem_RegWEN),
        .mem_dst   (mem_RegDst),
        .sel       (huif.forwardB)
    );

    forward_sel #(.REG_W(REG_W)) u_fwd_sw (
        .src_reg   (idex_rt),
        .en        (idex_MemWrite),
        .exmem_wen (exmem_RegWEN),
        .exmem_dst (exmem_RegDst),
        .mem_wen   (mem_RegWEN),
        .mem_dst   (mem_RegDst),
        .sel       (huif.forwardSW)
    );

    // Next stall flag and saturating stall counter
    always_comb begin
        stalled_d     = hz_s;
        stall_count_d = stall_count_q;
        if (hz_s && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Stall tracking registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stalled_q     <= 1'b0;
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            stalled_q     <= stalled_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign huif.stalled     = stalled_q;
    assign huif.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes model predictions, negedge monitor compares.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    localparam int TB_CNT_W = 4;
    localparam int MAXC     = (1 << TB_CNT_W) - 1;

    typedef struct packed {
        logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt;
        logic       mem_read, idex_mw;
        logic [4:0] stall_rt;
        logic       ex_wen;
        logic [4:0] ex_dst;
        logic       mem_wen;
        logic [4:0] mem_dst;
    } stim_t;

    typedef struct {
        logic       pc_en, ifid_en, flush;
        logic [1:0] fa, fb, fsw;
        logic       stalled;
        int         count;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [4:0] ifid_rs = 5'd0, ifid_rt = 5'd0, idex_rs = 5'd0, idex_rt = 5'd0;
    logic       mem_read = 1'b0, idex_mw = 1'b0;
    logic [4:0] stall_rt = 5'd0;
    logic       ex_wen = 1'b0, mem_wen = 1'b0;
    logic [4:0] ex_dst = 5'd0, mem_dst = 5'd0;

    hazard_unit_if #(.CNT_W(TB_CNT_W)) huif ();

    hazard_unit #(.REG_W(5), .CNT_W(TB_CNT_W)) dut (
        .CLK           (clk),
        .nRST          (nrst),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .idex_rs       (idex_rs),
        .idex_rt       (idex_rt),
        .MemRead       (mem_read),
        .idex_MemWrite (idex_mw),
        .stall_rt      (stall_rt),
        .exmem_RegWEN  (ex_wen),
        .exmem_RegDst  (ex_dst),
        .mem_RegWEN    (mem_wen),
        .mem_RegDst    (mem_dst),
        .huif          (huif)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference state: stall flag seen by the DUT this cycle, total stalls, last cycle's hazard
    bit   m_stalled = 1'b0;
    int   m_count = 0;
    bit   last_hz = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(logic [4:0] src, logic ew, logic [4:0] ed,
                                           logic mw, logic [4:0] md);
        if (ew && ed != 5'd0 && ed == src) return 2'b10;
        if (mw && md != 5'd0 && md == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // One pipeline cycle: advance the model over the edge, drive, optionally pulse reset, predict
    task automatic apply(stim_t s, bit pulse_rst);
        exp_t e;
        bit   hz;
        @(posedge clk);
        m_stalled = last_hz;
        if (last_hz && m_count < MAXC) m_count++;
        #1;
        ifid_rs = s.ifid_rs;  ifid_rt = s.ifid_rt;
        idex_rs = s.idex_rs;  idex_rt = s.idex_rt;
        mem_read = s.mem_read; idex_mw = s.idex_mw; stall_rt = s.stall_rt;
        ex_wen = s.ex_wen; ex_dst = s.ex_dst; mem_wen = s.mem_wen; mem_dst = s.mem_dst;
        if (pulse_rst) begin
            #1 nrst = 1'b0;
            #1;
            chk("midrst_stalled", 32'(huif.stalled), 32'd0);
            chk("midrst_count", 32'(huif.stall_count), 32'd0);
            nrst = 1'b1;
            m_stalled = 1'b0;
            m_count = 0;
        end
        hz = s.mem_read && s.stall_rt != 5'd0 &&
             (s.stall_rt == s.ifid_rs || s.stall_rt == s.ifid_rt) && !m_stalled;
        e.pc_en   = !hz;
        e.ifid_en = !hz;
        e.flush   = hz;
        e.fa      = ref_fwd(s.idex_rs, s.ex_wen, s.ex_dst, s.mem_wen, s.mem_dst);
        e.fb      = ref_fwd(s.idex_rt, s.ex_wen, s.ex_dst, s.mem_wen, s.mem_dst);
        e.fsw     = s.idex_mw ? e.fb : 2'b00;
        e.stalled = m_stalled;
        e.count   = m_count;
        exp_q.push_back(e);
        last_hz = hz;
    endtask

    // Monitor: compare the DUT against the oldest prediction, away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_en", 32'(huif.pc_en), 32'(e.pc_en));
            chk("ifid_en", 32'(huif.ifid_en), 32'(e.ifid_en));
            chk("idex_flush", 32'(huif.idex_flush), 32'(e.flush));
            chk("forwardA", 32'(huif.forwardA), 32'(e.fa));
            chk("forwardB", 32'(huif.forwardB), 32'(e.fb));
            chk("forwardSW", 32'(huif.forwardSW), 32'(e.fsw));
            chk("stalled", 32'(huif.stalled), 32'(e.stalled));
            chk("stall_count", 32'(huif.stall_count), e.count);
        end
    end

    initial begin
        stim_t s;
        #3;
        chk("reset_stalled", 32'(huif.stalled), 32'd0);
        chk("reset_count", 32'(huif.stall_count), 32'd0);
        chk("reset_pc_en", 32'(huif.pc_en), 32'd1);
        chk("reset_ifid_en", 32'(huif.ifid_en), 32'd1);
        chk("reset_flush", 32'(huif.idex_flush), 32'd0);
        chk("reset_fwdA", 32'(huif.forwardA), 32'd0);
        chk("reset_fwdB", 32'(huif.forwardB), 32'd0);
        chk("reset_fwdSW", 32'(huif.forwardSW), 32'd0);
        #9 nrst = 1'b1;

        // Load-use on rs: one stall, then held inputs do not re-stall
        s = idle(); s.mem_read = 1'b1; s.stall_rt = 5'd5; s.ifid_rs = 5'd5;
        apply(s, 1'b0);
        apply(s, 1'b0);
        apply(idle(), 1'b0);

        // Load into $0 never stalls
        s = idle(); s.mem_read = 1'b1;
        apply(s, 1'b0);

        // Load-use on rt
        s = idle(); s.mem_read = 1'b1; s.stall_rt = 5'd9; s.ifid_rt = 5'd9; s.ifid_rs = 5'd2;
        apply(s, 1'b0);
        apply(idle(), 1'b0);

        // MEM beats WB, then WB alone
        s = idle(); s.idex_rs = 5'd3; s.ex_wen = 1'b1; s.ex_dst = 5'd3;
        s.mem_wen = 1'b1; s.mem_dst = 5'd3;
        apply(s, 1'b0);
        s.ex_wen = 1'b0;
        apply(s, 1'b0);

        // Writes to $0 never forward
        s = idle(); s.ex_wen = 1'b1; s.mem_wen = 1'b1; s.idex_mw = 1'b1;
        apply(s, 1'b0);

        // Store data forwarding follows MemWrite
        s = idle(); s.idex_mw = 1'b1; s.idex_rt = 5'd8; s.mem_wen = 1'b1; s.mem_dst = 5'd8;
        apply(s, 1'b0);
        s.idex_mw = 1'b0;
        apply(s, 1'b0);

        // Held load-use pattern stalls every other cycle until the counter saturates
        s = idle(); s.mem_read = 1'b1; s.stall_rt = 5'd7; s.ifid_rs = 5'd7;
        for (int i = 0; i < 40; i++) apply(s, 1'b0);

        // Reset pulse while stalled: state clears and the hazard re-evaluates
        apply(idle(), 1'b0);
        apply(s, 1'b0);
        apply(s, 1'b1);
        apply(s, 1'b0);
        apply(s, 1'b0);

        // Randomized traffic over a small register range to get frequent matches
        for (int i = 0; i < 400; i++) begin
            s.ifid_rs  = 5'($urandom_range(0, 7));
            s.ifid_rt  = 5'($urandom_range(0, 7));
            s.idex_rs  = 5'($urandom_range(0, 7));
            s.idex_rt  = 5'($urandom_range(0, 7));
            s.mem_read = 1'($urandom_range(0, 1));
            s.idex_mw  = 1'($urandom_range(0, 1));
            s.stall_rt = 5'($urandom_range(0, 7));
            s.ex_wen   = 1'($urandom_range(0, 1));
            s.ex_dst   = 5'($urandom_range(0, 7));
            s.mem_wen  = 1'($urandom_range(0, 1));
            s.mem_dst  = 5'($urandom_range(0, 7));
            apply(s, ($urandom_range(0, 49) == 0));
        end

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
